// File: rtl/conv_ctrl_32_10.sv
// Control sequencer for a single-MAC 1D convolution: loads N input words, then
// walks the M taps for each of the N-M+1 outputs and hands each result downstream.
module conv_ctrl_32_10 #(
    parameter int N = 32,
    parameter int M = 10,
    localparam int XW = $clog2(N),
    localparam int FW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    output logic          wr_en_x,
    output logic [XW-1:0] addr_x,
    output logic [FW-1:0] addr_f,
    output logic          clear_acc,
    output logic          en_acc,
    output logic          m_valid_y,
    input  logic          m_ready_y,
    output logic          vec_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    localparam logic [XW-1:0] W_LAST = XW'(N - 1);
    localparam logic [XW-1:0] O_LAST = XW'(N - M);
    localparam logic [FW-1:0] K_LAST = FW'(M - 1);
    localparam logic [XW-1:0] X_INC  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0] K_INC  = {{(FW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [XW-1:0] wcnt_r;
    logic [FW-1:0] k_r;
    logic [XW-1:0] oidx_r;
    logic          en_d_r;
    logic [XW-1:0] sum_s;

    // oidx+k peaks at N-1, so the read address never wraps
    assign sum_s = oidx_r + XW'(k_r);

    // State machine and counters; k parks at M-1 after the last tap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            wcnt_r  <= {XW{1'b0}};
            k_r     <= {FW{1'b0}};
            oidx_r  <= {XW{1'b0}};
            en_d_r  <= 1'b0;
        end else begin
            en_d_r <= (state_r == ST_COMPUTE);
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (s_valid_x) begin
                        if (wcnt_r == W_LAST) begin
                            wcnt_r  <= {XW{1'b0}};
                            oidx_r  <= {XW{1'b0}};
                            k_r     <= {FW{1'b0}};
                            state_r <= ST_COMPUTE;
                        end else begin
                            wcnt_r <= wcnt_r + X_INC;
                        end
                    end else begin
                        wcnt_r <= wcnt_r;
                    end
                end
                ST_COMPUTE: begin
                    if (k_r == K_LAST) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        k_r <= k_r + K_INC;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (m_ready_y) begin
                        if (oidx_r == O_LAST) begin
                            wcnt_r  <= {XW{1'b0}};
                            state_r <= ST_LOAD;
                        end else begin
                            oidx_r  <= oidx_r + X_INC;
                            k_r     <= {FW{1'b0}};
                            state_r <= ST_COMPUTE;
                        end
                    end else begin
                        state_r <= ST_OUTPUT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state and counters
    always_comb begin
        s_ready_x = 1'b0;
        addr_x    = {XW{1'b0}};
        addr_f    = {FW{1'b0}};
        clear_acc = 1'b0;
        m_valid_y = 1'b0;
        vec_done  = 1'b0;
        case (state_r)
            ST_LOAD: begin
                s_ready_x = 1'b1;
                addr_x    = wcnt_r;
            end
            ST_COMPUTE: begin
                addr_x    = sum_s;
                addr_f    = k_r;
                clear_acc = (k_r == {FW{1'b0}});
            end
            ST_DRAIN: begin
                addr_x = sum_s;
                addr_f = k_r;
            end
            ST_OUTPUT: begin
                addr_x    = sum_s;
                addr_f    = k_r;
                m_valid_y = 1'b1;
                vec_done  = m_ready_y && (oidx_r == O_LAST);
            end
            default: begin
                s_ready_x = 1'b0;
            end
        endcase
        wr_en_x = s_valid_x & s_ready_x;
        en_acc  = en_d_r;
    end

endmodule
